ip_rx_filter: RTL

IP_RX_FILTER -- requirements
Module: ip_rx_filter

---
 rtl/ip_filter_pkg.sv | 32 +++
 rtl/ip_rx_filter_sat_counter.sv | 25 ++
 rtl/ip_rx_filter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ip_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ip_filter_pkg
// Brief    : Shared state encoding, constants and address-match helper for
//            the IP receive filter.
// Revision : 1.0
// ============================================================================
package ip_filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PASS = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    localparam logic [7:0]  PROTO_UDP = 8'd17;
    localparam logic [31:0] IP_BCAST  = 32'hFFFF_FFFF;

    // Unicast to us, limited broadcast, or directed broadcast on our subnet.
    function automatic logic dest_match(
        input logic [31:0] dest,
        input logic [31:0] local_ip,
        input logic [31:0] subnet_mask
    );
        return (dest == local_ip) ||
               (dest == IP_BCAST) ||
               (dest == (local_ip | ~subnet_mask));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ip_rx_filter_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating event counter; holds at all-ones instead of wrapping.
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ip_rx_filter.sv
`default_nettype none
// ============================================================================
// Module   : ip_rx_filter
// Brief    : Accepts IP packets of one protocol addressed to this station,
//            forwards them and discards everything else, with statistics.
// Revision : 1.0
// ============================================================================
module ip_rx_filter
    import ip_filter_pkg::*;
#(
    parameter logic [7:0] PROTOCOL  = PROTO_UDP,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          local_ip,
    input  logic [31:0]          subnet_mask,

    input  logic                 s_ip_hdr_valid,
    output logic                 s_ip_hdr_ready,
    input  logic [5:0]           s_ip_dscp,
    input  logic [1:0]           s_ip_ecn,
    input  logic [15:0]          s_ip_length,
    input  logic [7:0]           s_ip_ttl,
    input  logic [7:0]           s_ip_protocol,
    input  logic [31:0]          s_ip_source_ip,
    input  logic [31:0]          s_ip_dest_ip,
    input  logic [7:0]           s_ip_payload_axis_tdata,
    input  logic                 s_ip_payload_axis_tvalid,
    output logic                 s_ip_payload_axis_tready,
    input  logic                 s_ip_payload_axis_tlast,
    input  logic                 s_ip_payload_axis_tuser,

    output logic                 m_ip_hdr_valid,
    input  logic                 m_ip_hdr_ready,
    output logic [5:0]           m_ip_dscp,
    output logic [1:0]           m_ip_ecn,
    output logic [15:0]          m_ip_length,
    output logic [7:0]           m_ip_ttl,
    output logic [7:0]           m_ip_protocol,
    output logic [31:0]          m_ip_source_ip,
    output logic [31:0]          m_ip_dest_ip,
    output logic [7:0]           m_ip_payload_axis_tdata,
    output logic                 m_ip_payload_axis_tvalid,
    input  logic                 m_ip_payload_axis_tready,
    output logic                 m_ip_payload_axis_tlast,
    output logic                 m_ip_payload_axis_tuser,

    output logic [CNT_WIDTH-1:0] pass_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    state_t r_state;
    state_t w_next;
    logic   w_hdr_fire;
    logic   w_match;
    logic   w_pass_done;
    logic   w_drop_done;
    logic   w_err_done;

    // Match is decided from the live header so the verdict lands with the
    // registered fields on the very next cycle.
    assign w_hdr_fire = (r_state == ST_IDLE) && s_ip_hdr_valid;
    assign w_match    = (s_ip_protocol == PROTOCOL) &&
                        dest_match(s_ip_dest_ip, local_ip, subnet_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            m_ip_dscp      <= '0;
            m_ip_ecn       <= '0;
            m_ip_length    <= '0;
            m_ip_ttl       <= '0;
            m_ip_protocol  <= '0;
            m_ip_source_ip <= '0;
            m_ip_dest_ip   <= '0;
        end else begin
            r_state <= w_next;
            if (w_hdr_fire) begin
                m_ip_dscp      <= s_ip_dscp;
                m_ip_ecn       <= s_ip_ecn;
                m_ip_length    <= s_ip_length;
                m_ip_ttl       <= s_ip_ttl;
                m_ip_protocol  <= s_ip_protocol;
                m_ip_source_ip <= s_ip_source_ip;
                m_ip_dest_ip   <= s_ip_dest_ip;
            end
        end
    end

    always_comb begin
        w_next                   = r_state;
        s_ip_hdr_ready           = 1'b0;
        m_ip_hdr_valid           = 1'b0;
        s_ip_payload_axis_tready = 1'b0;
        m_ip_payload_axis_tvalid = 1'b0;
        m_ip_payload_axis_tdata  = '0;
        m_ip_payload_axis_tlast  = 1'b0;
        m_ip_payload_axis_tuser  = 1'b0;
        w_pass_done              = 1'b0;
        w_drop_done              = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s_ip_hdr_ready = 1'b1;
                if (s_ip_hdr_valid) begin
                    w_next = w_match ? ST_HDR : ST_DROP;
                end
            end
            ST_HDR: begin
                m_ip_hdr_valid = 1'b1;
                if (m_ip_hdr_ready) begin
                    w_next = ST_PASS;
                end
            end
            ST_PASS: begin
                s_ip_payload_axis_tready = m_ip_payload_axis_tready;
                m_ip_payload_axis_tvalid = s_ip_payload_axis_tvalid;
                m_ip_payload_axis_tdata  = s_ip_payload_axis_tdata;
                m_ip_payload_axis_tlast  = s_ip_payload_axis_tlast;
                m_ip_payload_axis_tuser  = s_ip_payload_axis_tuser;
                if (s_ip_payload_axis_tvalid && m_ip_payload_axis_tready &&
                    s_ip_payload_axis_tlast) begin
                    w_next      = ST_IDLE;
                    w_pass_done = 1'b1;
                end
            end
            ST_DROP: begin
                s_ip_payload_axis_tready = 1'b1;
                if (s_ip_payload_axis_tvalid && s_ip_payload_axis_tlast) begin
                    w_next      = ST_IDLE;
                    w_drop_done = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_err_done = w_pass_done && s_ip_payload_axis_tuser;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_pass_done),
        .count (pass_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_drop_done),
        .count (drop_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_err_done),
        .count (err_count)
    );

endmodule
`default_nettype wire
